// File: rtl/saber_mem_pkg.sv
// Shared constants and FSM state encoding for the Saber memory-side helpers.
package saber_mem_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned LEN_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CAP,
    WR,
    END,
    SCRUB,
    DONE
  } state_t;

endpackage

// File: rtl/ct_select.sv
// Constant-time bitwise select: y = m ? b : a per bit, with no data-dependent mux.
module ct_select #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] y
);

  assign y = a ^ (m & (a ^ b));

endmodule

// File: rtl/cmov_write.sv
// Constant-time conditional move: dest[i] = sel ? B[i] : A[i], fixed 4-cycle-per-word schedule.
// Define CMOV_SCRUB_EN to clear operand and mask registers for one cycle before DONE.
module cmov_write #(
  parameter int unsigned DATA_W = saber_mem_pkg::DATA_W,
  parameter int unsigned ADDR_W = saber_mem_pkg::ADDR_W,
  parameter int unsigned LEN_W  = saber_mem_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel,
  input  logic [LEN_W-1:0]  ilen,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_base_sel,
  input  logic [DATA_W-1:0] din,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  import saber_mem_pkg::*;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  idx, len_reg;
  logic [DATA_W-1:0] a_reg, b_reg, mask;
  logic              accept, last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == (len_reg - LEN_W'(1)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (ilen == '0) ? DONE : RD0;
      RD0:        state_nxt = RD1;
      RD1:        state_nxt = CAP;
      CAP:        state_nxt = WR;
      WR:         state_nxt = last ? END : RD0;
`ifdef CMOV_SCRUB_EN
      END:        state_nxt = SCRUB;
      SCRUB:      state_nxt = DONE;
`else
      END:        state_nxt = DONE;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  // sel is folded into a full-width mask at start so the datapath never branches on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      len_reg <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      mask    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mask    <= {DATA_W{sel}};
        len_reg <= ilen;
        idx     <= '0;
      end
      if (state == RD1) a_reg <= din;
      if (state == CAP) b_reg <= din;
      if ((state == WR) && !last) idx <= idx + LEN_W'(1);
`ifdef CMOV_SCRUB_EN
      if (state == SCRUB) begin
        a_reg <= '0;
        b_reg <= '0;
        mask  <= '0;
      end
`endif
    end
  end

  assign rd_address  = idx[ADDR_W-1:0];
  assign wr_address  = idx[ADDR_W-1:0];
  assign rd_base_sel = (state == RD1);
  assign wr_en       = (state == WR);
  assign done        = (state == DONE);

  ct_select #(.W(DATA_W)) u_ct_select (
    .a (a_reg),
    .b (b_reg),
    .m (mask),
    .y (dout)
  );

endmodule

// File: tb/tb_cmov_write.sv
// Randomized self-checking bench for cmov_write against an array-based reference of dest[i] = sel ? B[i] : A[i].
module tb_cmov_write;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sel;
  logic [LW-1:0] ilen;
  logic [AW-1:0] rd_address;
  logic          rd_base_sel;
  logic [DW-1:0] din = '0;
  logic          wr_en;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] dout;
  logic          done;

  always #5 clk = ~clk;

  cmov_write #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sel         (sel),
    .ilen        (ilen),
    .rd_address  (rd_address),
    .rd_base_sel (rd_base_sel),
    .din         (din),
    .wr_en       (wr_en),
    .wr_address  (wr_address),
    .dout        (dout),
    .done        (done)
  );

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) din <= rd_base_sel ? mem_b[rd_address] : mem_a[rd_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wq_addr [$];
  logic [DW-1:0] wq_data [$];
  int            wq_cyc  [$];

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_address));
      wq_data.push_back(dout);
      wq_cyc.push_back(cyc);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int done_offset(input int n);
    int off;
    if (n == 0) return 0;
    off = 4 * n + 1;
`ifdef CMOV_SCRUB_EN
    off = off + 1;
`endif
    return off;
  endfunction

  task automatic run(input int n, input bit s, input bit noise);
    int t0, t1;
    bit seen;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    ilen  = LW'(n);
    @(negedge clk);
    start = 1'b0;
    sel   = 1'($urandom);
    ilen  = LW'($urandom);
    t0    = cyc;
    t1    = 0;
    seen  = 1'b0;
    for (int k = 0; k < 4 * n + 20 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
        t1   = cyc;
      end else begin
        if (noise && ($urandom_range(3) == 0)) begin
          start = 1'b1;
          sel   = 1'($urandom);
          ilen  = LW'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    if (seen) check("done_latency", 64'(t1 - t0), 64'(done_offset(n)));
    check("write_count", 64'(wq_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check("wr_address", 64'(wq_addr[i]), 64'(i));
      check("wr_data", wq_data[i], s ? mem_b[i] : mem_a[i]);
      check("wr_slot", 64'(wq_cyc[i] - t0), 64'(4 * i + 3));
    end
    check("wr_en_after_done", 64'(wr_en), 64'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    ilen  = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_rd_address", 64'(rd_address), 64'd0);
    check("rst_rd_base_sel", 64'(rd_base_sel), 64'd0);
    check("rst_wr_address", 64'(wr_address), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      mem_a[i] = 64'(i + 1);
      mem_b[i] = 64'd9;
    end
    run(3, 1'b0, 1'b0);
    run(3, 1'b1, 1'b0);
    run(0, 1'b1, 1'b0);

    fill_random();
    for (int r = 0; r < 24; r++) begin
      run(int'($urandom_range(12)), 1'($urandom), 1'b1);
    end

    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 64'(i);
      mem_b[i] = ~64'(i);
    end
    run(512, 1'b1, 1'b0);
    check("last_addr_512", (wq_addr.size() == 512) ? 64'(wq_addr[511]) : 64'hdead, 64'd511);
    check("last_data_512", (wq_data.size() == 512) ? wq_data[511] : 64'hdead, ~64'd511);

    fill_random();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    sel   = 1'b1;
    ilen  = LW'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    check("abort_pre_wr_en", 64'(wr_en), 64'd1);
    check("abort_pre_addr", 64'(wr_address), 64'd5);
    rst = 1'b0;
    #1;
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_dout", dout, 64'd0);
    check("abort_rd_address", 64'(rd_address), 64'd0);
    check("abort_writes", 64'(wq_addr.size()), 64'd5);
    repeat (2) @(negedge clk);
    check("abort_no_write", 64'(wq_addr.size()), 64'd5);
    rst = 1'b1;
    run(4, 1'b0, 1'b0);
    run(5, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
